data_ram_ctrl: RTL
==================

Name: data_ram_ctrl

Overview:
- Data-memory responder on the far end of the MEM stage's load/store request interface.
- Accepts one word-addressed request at a time from the MEM stage and holds the pipeline with stallreq_o for a fixed latency.
- Returns read data or commits byte-masked write data to an internal synchronous RAM array.
- Sits between the MEM stage and the (modelled) data memory; stallreq_o feeds the pipeline stall controller.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_ce_i  input  1  request valid from MEM stage.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address; bits [ADDR_W+1:2] select the word.
- mem_sel_i  input  4  byte enables; sel[3] = bits 31:24 (big-endian lane order).
- mem_data_i  input  32  store data.
- mem_data_o  output  32  load data, valid in DONE cycle only.
- stallreq_o  output  1  pipeline hold request.

Behaviour:
- States: IDLE, BUSY, DONE. Counter cnt is 4 bits.
- Reset (rst=1 at clock edge):
  - state=IDLE, cnt=0, all captured request registers=0.
  - mem_data_o=0, stallreq_o=0.
  - RAM contents are not cleared.
- IDLE:
  - mem_ce_i=1: capture we/addr/sel/data and load cnt=LATENCY-1.
    - LATENCY=1: go to DONE.
    - Otherwise: go to BUSY.
  - stallreq_o=mem_ce_i (combinational) in IDLE, so the request cycle is stalled.
- BUSY:
  - stallreq_o=1; cnt decrements each cycle.
  - Go to DONE when cnt==1 at a clock edge.
  - Inputs are ignored after capture.
- DONE: lasts exactly one cycle.
  - stallreq_o=0.
  - Load: mem_data_o=RAM[captured word addr], the full word; lane extraction and sign extension belong to the MEM stage.
  - Store: at the end of the DONE cycle, write each byte lane whose sel bit is 1. mem_data_o=0.
  - Next state is IDLE.
- Timing: a request first seen at cycle T completes in cycle T+LATENCY. The pipeline advances at the end of that cycle.
- mem_data_o=0 in every cycle other than a load DONE cycle.
- Back-to-back requests:
  - A new request is first seen in the IDLE cycle following DONE.
  - Sustained throughput is one access per LATENCY+1 cycles.
- Held request: if the pipeline is frozen by another source and the same request is still presented after DONE, it re-executes. Loads are harmless; stores are idempotent. This is accepted behaviour.
- Addressing:
  - mem_addr_i[1:0] is ignored; no misalignment detection.
  - Bits above ADDR_W+1 are ignored (aliasing) unless the optional feature is compiled in.
- Store with sel=4'b0000 completes normally with timing unchanged and writes nothing.
- Reset mid-operation (BUSY or DONE): the transaction is aborted, no RAM write occurs, and the block returns to IDLE.
- Read-after-write ordering: a load following a store to the same word returns the new data. This is guaranteed because the store commits at the end of DONE, before the next IDLE capture.

Optional Feature:
- Macro: DRAM_RANGE_CHECK_EN.
- Defined:
  - Adds output addr_err_o (1 bit, reset 0).
  - The captured address is out of range if any of mem_addr_i[31:ADDR_W+2] is nonzero.
  - An out-of-range transaction keeps normal timing, suppresses the RAM write, and forces mem_data_o=0.
  - addr_err_o=1 for exactly the DONE cycle, 0 otherwise.
- Undefined: the port is absent and upper address bits alias.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to addr 0x10, sel=4'hF, then load 0x10 -> stallreq_o=1 for 2 cycles per access; load DONE cycle shows mem_data_o=0xDEADBEEF.
- Byte store 0x000000AA to addr 0x10, sel=4'b0001 -> subsequent load returns 0xDEADBEAA. Then sel=4'b1000 with data 0x11000000 -> load returns 0x11ADBEAA.
- mem_ce_i=0 for 10 cycles -> stallreq_o=0 and mem_data_o=0 throughout, state stays IDLE.
- Store 0x12345678 to 0x20, rst=1 during the BUSY cycle -> stallreq_o=0 next cycle; later load of 0x20 returns the prior contents, not 0x12345678.
- Back-to-back store then load to the same address with LATENCY=1 -> each access stalls 1 cycle, DONE cycles 2 apart, load returns the just-stored value.
- DRAM_RANGE_CHECK_EN, ADDR_W=10: load from 0x00001000 -> addr_err_o=1 in DONE, mem_data_o=0. Store to 0x00001000 leaves word 0 unchanged. Without the macro, a store to 0x00001000 modifies word 0.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Data-memory responder for the MEM stage: fixed-latency word load/store into an internal RAM.
// Defining DRAM_RANGE_CHECK_EN adds addr_err_o and blocks accesses with nonzero upper address bits.
module data_ram_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
`ifdef DRAM_RANGE_CHECK_EN
    output logic        addr_err_o,
`endif
    output logic        stallreq_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              cap_en;

    logic              req_we;
    logic [ADDR_W-1:0] req_idx;
    logic [3:0]        req_sel;
    logic [31:0]       req_data;
    logic              req_oor;

    logic [ADDR_W-1:0] in_idx;
    logic              in_oor;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_go;
    logic              err_go;
    logic              wr_go;

    logic [31:0]       ram [DEPTH];

    assign in_idx = mem_addr_i[ADDR_W+1:2];

`ifdef DRAM_RANGE_CHECK_EN
    assign in_oor = |mem_addr_i[31:ADDR_W+2];
`else
    assign in_oor = 1'b0;
`endif

    // Byte offset (and, without range checking, the upper bits) take no part in addressing.
    logic addr_unused;
    assign addr_unused = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // Next-state, counter and stall request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cap_en     = 1'b0;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                stallreq_o = mem_ce_i;
                if (mem_ce_i) begin
                    cap_en     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stallreq_o = 1'b1;
                cnt_next   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the request goes straight to DONE, so the read uses the live inputs.
    assign rd_idx = cap_en ? in_idx : req_idx;
    assign err_go = (state_next == DONE) && (cap_en ? in_oor : req_oor);
    assign rd_go  = (state_next == DONE) && !(cap_en ? (mem_we_i | in_oor) : (req_we | req_oor));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_we     <= 1'b0;
            req_idx    <= '0;
            req_sel    <= '0;
            req_data   <= '0;
            req_oor    <= 1'b0;
            mem_data_o <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (cap_en) begin
                req_we   <= mem_we_i;
                req_idx  <= in_idx;
                req_sel  <= mem_sel_i;
                req_data <= mem_data_i;
                req_oor  <= in_oor;
            end
            mem_data_o <= rd_go ? ram[rd_idx] : 32'h0;
        end
    end

`ifdef DRAM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_o <= 1'b0;
        end else begin
            addr_err_o <= err_go;
        end
    end
`else
    logic err_unused;
    assign err_unused = err_go;
`endif

    // Store commits at the end of DONE; a reset in that cycle aborts it.
    assign wr_go = (state == DONE) && req_we && !req_oor && !rst;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    ram[req_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

endmodule
